// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer.
// Holds the pattern modes, the bounce direction and the seed helper.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_SHL    = 2'd0,
    MODE_SHR    = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BIN    = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam int   SYNC_STAGES_DEFAULT = 2;
  localparam logic SEED_ONEHOT_LSB     = 1'b1;

  // LSB of the seed pattern; every other seed bit is zero.
  function automatic logic seed_lsb(mode_t m);
    return (m == MODE_BIN) ? 1'b0 : SEED_ONEHOT_LSB;
  endfunction

endpackage

// File: rtl/led_seq_sync_edge_det.sv
// Synchroniser chain plus rising-edge detector for an asynchronous level.
// Also intended for push-button inputs.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [STAGES-1:0] sync_reg;
  logic              prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], din};
      prev_reg <= sync_reg[STAGES-1];
    end
  end

  // prev keeps tracking regardless of pause, so a released pause never sees a stale edge.
  assign rise = sync_reg[STAGES-1] & ~prev_reg;

endmodule

// File: rtl/led_seq.sv
// LED pattern sequencer: one pattern step per rising edge of the slow divider output.
// Patterns are rotate-left, rotate-right, bounce and binary count.
module led_seq
  import led_seq_pkg::*;
#(
  parameter int NLED        = 8,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            slow_in,
  input  mode_t           mode,
  input  logic            pause,
  output logic [NLED-1:0] led,
  output logic            tick
);

  logic            step;
  logic            accept;
  logic [NLED-1:0] led_reg, led_next;
  logic [NLED-1:0] seed_val, shl_val, shr_val, bounce_val, bin_val;
  dir_t            dir_reg, dir_next, dir_bounce;
  mode_t           mode_q_reg, mode_q_next;
  logic            tick_reg, tick_next;

  sync_edge_det #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (slow_in),
    .rise (step)
  );

  assign accept = step & ~pause;

  assign seed_val = {{(NLED-1){1'b0}}, seed_lsb(mode)};
  assign shl_val  = {led_reg[NLED-2:0], led_reg[NLED-1]};
  assign shr_val  = {led_reg[0], led_reg[NLED-1:1]};
  assign bin_val  = led_reg + 1'b1;

  // Direction flips on the step that lands on an end, so endpoints are shown once.
  always_comb begin
    bounce_val = led_reg;
    dir_bounce = dir_reg;
    if (dir_reg == DIR_LEFT) begin
      bounce_val = led_reg << 1;
      dir_bounce = bounce_val[NLED-1] ? DIR_RIGHT : DIR_LEFT;
    end else begin
      bounce_val = led_reg >> 1;
      dir_bounce = bounce_val[0] ? DIR_LEFT : DIR_RIGHT;
    end
  end

  always_comb begin
    led_next    = led_reg;
    dir_next    = dir_reg;
    mode_q_next = mode_q_reg;
    tick_next   = accept;
    if (accept) begin
      if (mode != mode_q_reg) begin
        led_next    = seed_val;
        dir_next    = DIR_LEFT;
        mode_q_next = mode;
      end else begin
        case (mode_q_reg)
          MODE_SHL:    led_next = shl_val;
          MODE_SHR:    led_next = shr_val;
          MODE_BOUNCE: begin
            led_next = bounce_val;
            dir_next = dir_bounce;
          end
          MODE_BIN:    led_next = bin_val;
          default:     led_next = led_reg;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_reg    <= {{(NLED-1){1'b0}}, 1'b1};
      dir_reg    <= DIR_LEFT;
      mode_q_reg <= MODE_SHL;
      tick_reg   <= 1'b0;
    end else begin
      led_reg    <= led_next;
      dir_reg    <= dir_next;
      mode_q_reg <= mode_q_next;
      tick_reg   <= tick_next;
    end
  end

  assign led  = led_reg;
  assign tick = tick_reg;

endmodule

// File: tb/tb_led_seq.sv
// Self-checking bench for led_seq: an 8-LED and a 4-LED instance against a pattern model.
// The model tracks positions/phases and sampled input history rather than register state.
module tb_led_seq;
  import led_seq_pkg::*;

  localparam int S    = 2;
  localparam int HMAX = 16384;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s8 = 1'b0, p8 = 1'b0, s4 = 1'b0, p4 = 1'b0;
  mode_t      md8 = MODE_SHL, md4 = MODE_SHL;
  logic [7:0] led8;
  logic [3:0] led4;
  logic       t8, t4;

  led_seq #(.NLED(8), .SYNC_STAGES(S)) dut8 (
    .clk(clk), .rst(rst), .slow_in(s8), .mode(md8), .pause(p8), .led(led8), .tick(t8)
  );
  led_seq #(.NLED(4), .SYNC_STAGES(S)) dut4 (
    .clk(clk), .rst(rst), .slow_in(s4), .mode(md4), .pause(p4), .led(led4), .tick(t4)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Model state
  int  cyc = 0;
  int  rst_cyc [2] = '{-1, -1};
  bit  samp [2][HMAX];
  int  m_led [2], m_pos [2], m_ph [2], m_mode [2];
  bit  m_tick [2];
  bit  started = 1'b0;
  int  got8[$], got4[$];

  // Value of slow_in captured at edge m, as still visible after any later reset.
  function automatic bit hv(int i, int m);
    if (m < 0 || m <= rst_cyc[i] || m >= HMAX) return 1'b0;
    return samp[i][m];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int n, md, idx;
      bit s, p, st;
      n  = (i == 0) ? 8 : 4;
      s  = (i == 0) ? s8 : s4;
      p  = (i == 0) ? p8 : p4;
      md = (i == 0) ? int'(md8) : int'(md4);
      if (cyc < HMAX) samp[i][cyc] = rst ? 1'b0 : s;
      if (rst) begin
        rst_cyc[i] = cyc;
        m_led[i] = 1; m_pos[i] = 0; m_ph[i] = 0; m_mode[i] = 0; m_tick[i] = 1'b0;
      end else begin
        // Step when the value seen S edges ago is high and the one before it low.
        st = hv(i, cyc - S) && !hv(i, cyc - S - 1);
        m_tick[i] = st && !p;
        if (m_tick[i]) begin
          if (md != m_mode[i]) begin
            m_mode[i] = md; m_pos[i] = 0; m_ph[i] = 0;
            m_led[i] = (md == 3) ? 0 : 1;
          end else begin
            case (m_mode[i])
              0: begin m_pos[i] = (m_pos[i] + 1) % n;     m_led[i] = 1 << m_pos[i]; end
              1: begin m_pos[i] = (m_pos[i] + n - 1) % n; m_led[i] = 1 << m_pos[i]; end
              2: begin
                m_ph[i]  = (m_ph[i] + 1) % (2 * n - 2);
                idx      = (m_ph[i] < n) ? m_ph[i] : (2 * n - 2 - m_ph[i]);
                m_led[i] = 1 << idx;
              end
              default: m_led[i] = (m_led[i] + 1) % (1 << n);
            endcase
          end
        end
      end
    end
    if (rst) started = 1'b1;
    cyc++;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("led8", int'(led8), m_led[0]);
      chk("tick8", int'(t8), int'(m_tick[0]));
      chk("led4", int'(led4), m_led[1]);
      chk("tick4", int'(t4), int'(m_tick[1]));
      if (t8) got8.push_back(int'(led8));
      if (t4) got4.push_back(int'(led4));
    end
  end

  task automatic cycles(int k);
    repeat (k) @(negedge clk);
  endtask

  // 8 high / 8 low; optionally pin the tick to exactly edge 2 after the first sampling edge.
  task automatic pulse(int w, bit timed);
    if (w == 0) s8 = 1'b1; else s4 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (timed && k < 3) chk("tick_lat", (w == 0) ? int'(t8) : int'(t4), (k == 2) ? 1 : 0);
    end
    if (w == 0) s8 = 1'b0; else s4 = 1'b0;
    cycles(8);
  endtask

  initial begin
    int shl_exp [9]     = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    int bnc_exp [16]    = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                            8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    int n4_exp [4]      = '{4'h2, 4'h4, 4'h8, 4'h1};

    @(negedge clk);
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    chk("rst_led8", int'(led8), 8'h01);
    chk("rst_tick8", int'(t8), 0);
    chk("rst_led4", int'(led4), 4'h1);

    // Rotate left
    got8.delete();
    for (int i = 0; i < 9; i++) pulse(0, 1'b1);
    chk("shl_cnt", got8.size(), 9);
    for (int i = 0; i < 9 && i < got8.size(); i++) chk("shl_seq", got8[i], shl_exp[i]);

    // Bounce
    md8 = MODE_BOUNCE;
    got8.delete();
    for (int i = 0; i < 16; i++) pulse(0, 1'b1);
    chk("bnc_cnt", got8.size(), 16);
    for (int i = 0; i < 16 && i < got8.size(); i++) chk("bnc_seq", got8[i], bnc_exp[i]);

    // Binary with wrap
    md8 = MODE_BIN;
    got8.delete();
    for (int i = 0; i < 257; i++) pulse(0, 1'b0);
    chk("bin_cnt", got8.size(), 257);
    if (got8.size() == 257) begin
      chk("bin_first", got8[0], 8'h00);
      chk("bin_ff", got8[255], 8'hFF);
      chk("bin_wrap", got8[256], 8'h00);
    end

    // Pause drops steps; release while high gives no step
    p8 = 1'b1;
    got8.delete();
    for (int i = 0; i < 3; i++) pulse(0, 1'b0);
    s8 = 1'b1;
    cycles(4);
    p8 = 1'b0;
    cycles(6);
    s8 = 1'b0;
    cycles(8);
    chk("pause_cnt", got8.size(), 0);
    chk("pause_led", int'(led8), 8'h00);
    pulse(0, 1'b1);
    chk("unpause_led", int'(led8), 8'h01);

    // Rotate right, then mode change applied after pause
    md8 = MODE_SHR;
    for (int i = 0; i < 3; i++) pulse(0, 1'b1);
    chk("shr_led", int'(led8), 8'h40);
    p8 = 1'b1;
    md8 = MODE_SHL;
    cycles(3);
    p8 = 1'b0;
    pulse(0, 1'b1);
    chk("modechg_led", int'(led8), 8'h01);

    // Reset one cycle before a pending step
    pulse(0, 1'b1);
    chk("pre_rst_led", int'(led8), 8'h02);
    s8 = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_led", int'(led8), 8'h01);
    chk("midrst_tick", int'(t8), 0);
    @(negedge clk);
    chk("midrst_led2", int'(led8), 8'h01);
    chk("midrst_tick2", int'(t8), 0);
    cycles(6);
    s8 = 1'b0;
    cycles(8);
    chk("rel_step_led", int'(led8), 8'h02);

    // NLED=4 rotate, then a one-cycle glitch
    got4.delete();
    for (int i = 0; i < 4; i++) pulse(1, 1'b1);
    chk("n4_cnt", got4.size(), 4);
    for (int i = 0; i < 4 && i < got4.size(); i++) chk("n4_seq", got4[i], n4_exp[i]);
    got4.delete();
    s4 = 1'b1;
    @(negedge clk);
    s4 = 1'b0;
    cycles(10);
    chk("glitch_le1", (got4.size() <= 1) ? 1 : 0, 1);
    pulse(1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
